spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
- SPI mode-0 target that receives register writes from an external controller and drives the five PWM control registers consumed by pwm_peripheral.
- The SPI pins arrive asynchronously on dedicated inputs, with ui_in[0]=SCLK, ui_in[1]=COPI and ui_in[2]=nCS.
- The block synchronises these pins into the clk domain, deserialises 16-bit frames and commits write frames atomically on nCS deassertion.
- Write-only: there is no CIPO and read frames are discarded.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (legal range 2..3)
MAX_ADDR, 7'h04, highest valid register address; addresses above this are ignored

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock, asynchronous to clk, idle low
copi  input  1  SPI serial data in, MSB first
ncs  input  1  SPI chip select, active low, asynchronous
en_reg_out_7_0  output  8  register 0x00
en_reg_out_15_8  output  8  register 0x01
en_reg_pwm_7_0  output  8  register 0x02
en_reg_pwm_15_8  output  8  register 0x03
pwm_duty_cycle  output  8  register 0x04
wr_strobe  output  1  one-clk pulse when a valid write commits

Behaviour:
- Reset is asynchronous, active-low and fixed. rst_n low forces the following immediately, independent of clk:
  - all five registers to 8'h00
  - wr_strobe to 0
  - bit counter to 0
  - shift register to 0
  - FSM to IDLE
  - synchroniser flops to idle values (sclk=0, copi=0, ncs=1)
- Synchronisation: sclk, copi and ncs each pass through SYNC_STAGES flops.
- Edge detection compares the last synchronised sample with one extra flop.
  - sclk_rise = prev 0 -> now 1.
  - ncs_fall and ncs_rise are defined the same way.
- Timing constraint: SCLK high time, SCLK low time and the nCS setup to the first SCLK rise must each be at least SYNC_STAGES+2 clk periods. Faster SCLK is out of spec.
- Frame format, 16 bits, MSB first:
  - bit15 = R/W (1 = write)
  - bits14:8 = address[6:0]
  - bits7:0 = data
- COPI is sampled on each synchronised sclk_rise, using the synchronised copi value at that cycle.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on ncs_fall, clear the bit counter (5 bits) and the shift register, then go to SHIFT.
  - SHIFT, while synchronised ncs == 0:
    - On each sclk_rise with counter < 16, shift copi into the LSB and increment the counter.
    - Once the counter reaches 16, further sclk_rise events are ignored; the counter saturates at 16 and the shift register is frozen.
  - SHIFT on ncs_rise: go to COMMIT.
  - COMMIT (exactly one clk cycle), then IDLE.
    - If counter == 16, shift[15] == 1 and shift[14:8] <= MAX_ADDR: write shift[7:0] into the addressed register and pulse wr_strobe high for this one cycle.
    - Otherwise do nothing: no register change and wr_strobe stays 0.
- Register outputs change on the clk edge that leaves COMMIT.
  - Latency from the first clk edge sampling ncs high to the register update is SYNC_STAGES+2 clk edges.
- Frames with fewer than 16 bits are discarded.
- Frames with more than 16 bits keep the first 16 bits and commit normally.
- Read frames (bit15 = 0) and addresses 0x05..0x7F are discarded silently; no register changes.
- Back-to-back frames: an ncs_fall during COMMIT is not lost.
  - IDLE samples the current synchronised ncs level: if ncs is low on entry, go directly to SHIFT with the counter cleared.
- sclk_rise while ncs is high is ignored in every state.
- Only one register is written per frame; the other four hold their values.
- rst_n asserted mid-frame aborts the frame: no partial commit and all registers return to 0.
- Registers hold their values indefinitely between writes.

Test Plan:
1. Reset: hold rst_n=0 for 5 clk with random pins -> all five registers = 8'h00 and wr_strobe = 0. Release reset with no SPI activity -> outputs stay 0.
2. Valid write: frame 16'h8455 (write, addr 0x04, data 0x55) at SCLK = clk/10.
   - pwm_duty_cycle = 8'h55 exactly SYNC_STAGES+2 clk edges after nCS rises.
   - wr_strobe is high for exactly one cycle.
   - The other registers remain 0.
3. All addresses: write 0x80A1, 0x81B2, 0x82C3, 0x83D4, 0x84E5 -> registers read A1, B2, C3, D4, E5 in address order, with 5 wr_strobe pulses total.
4. Rejected frames: each leaves all registers unchanged and wr_strobe never pulses.
   - read frame 16'h0477
   - write to address 0x05 (16'h8533)
   - 12-bit truncated frame
5. Over-length: 20 SCLK pulses, first 16 bits = 16'h82F0 -> en_reg_pwm_7_0 = 8'hF0 and wr_strobe pulses once.
6. Robustness:
   - Assert rst_n low after 9 bits of 16'h8399, then complete the frame -> no commit and all registers = 0.
   - Back-to-back frames 16'h8011 and 16'h8122 with nCS high for only SYNC_STAGES+2 clk between them -> both commit.

Source files
------------

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between an external controller and spi_peripheral.
`timescale 1ns/1ps

interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_peripheral.sv
// Write-only SPI mode-0 target that loads the five PWM control registers,
// committing each 16-bit write frame atomically when nCS deasserts.
//
// state  | meaning
// IDLE   | waiting for synchronised nCS low; clears bit counter and shift register
// SHIFT  | sampling COPI on synchronised SCLK rises, up to 16 bits
// COMMIT | one cycle; writes the addressed register if the frame is a valid write
`timescale 1ns/1ps

module spi_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_peripheral_if.slave     spi,
    output logic [7:0]          en_reg_out_7_0,
    output logic [7:0]          en_reg_out_15_8,
    output logic [7:0]          en_reg_pwm_7_0,
    output logic [7:0]          en_reg_pwm_15_8,
    output logic [7:0]          pwm_duty_cycle,
    output logic                wr_strobe
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_d, ncs_d;
    logic                   sclk_rise, ncs_rise;
    logic [4:0]             bit_cnt;
    logic [15:0]            shift_q;
    logic                   frame_ok;
    logic                   clear_frame;
    logic                   shift_en;

    // Synchronisers reset to the idle bus: SCLK low, COPI low, nCS high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi.copi};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            sclk_d    <= sclk_s;
            ncs_d     <= ncs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    assign frame_ok = (bit_cnt == 5'd16) && shift_q[15] && (shift_q[14:8] <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // IDLE follows the nCS level so a fall that lands during COMMIT is still caught
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!ncs_s) next_state = SHIFT;
            SHIFT:   if (ncs_rise) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        clear_frame = 1'b0;
        shift_en    = 1'b0;
        wr_strobe   = 1'b0;
        case (state)
            IDLE:    clear_frame = !ncs_s;
            SHIFT:   shift_en    = !ncs_s && sclk_rise && (bit_cnt < 5'd16);
            COMMIT:  wr_strobe   = frame_ok;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 5'd0;
            shift_q <= 16'h0000;
        end else if (clear_frame) begin
            bit_cnt <= 5'd0;
            shift_q <= 16'h0000;
        end else if (shift_en) begin
            bit_cnt <= bit_cnt + 5'd1;
            shift_q <= {shift_q[14:0], copi_s};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else if (wr_strobe) begin
            case (shift_q[14:8])
                7'h00:   en_reg_out_7_0  <= shift_q[7:0];
                7'h01:   en_reg_out_15_8 <= shift_q[7:0];
                7'h02:   en_reg_pwm_7_0  <= shift_q[7:0];
                7'h03:   en_reg_pwm_15_8 <= shift_q[7:0];
                7'h04:   pwm_duty_cycle  <= shift_q[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: directed and random SPI frames against a
// frame-level register model with fixed commit latency.
`timescale 1ns/1ps

module tb_spi_peripheral;

    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    typedef struct {
        int         at;
        logic [6:0] addr;
        logic [7:0] data;
    } commit_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe;

    spi_peripheral_if spi ();

    spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (spi),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         strobes = 0;
    int         exp_commits = 0;
    commit_t    pend[$];
    logic [7:0] exp_reg[5];
    logic       exp_strobe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Model: registers take the committed value LAT edges after nCS is first sampled high
    always @(negedge clk) begin
        exp_strobe = 1'b0;
        if (!rst_n) begin
            foreach (exp_reg[i]) exp_reg[i] = 8'h00;
            pend.delete();
        end else begin
            while (pend.size() > 0 && pend[0].at <= cyc) begin
                exp_reg[int'(pend[0].addr)] = pend[0].data;
                void'(pend.pop_front());
            end
            exp_strobe = (pend.size() > 0) && (pend[0].at == cyc + 1);
        end
        check("reg0", en_reg_out_7_0,  exp_reg[0]);
        check("reg1", en_reg_out_15_8, exp_reg[1]);
        check("reg2", en_reg_pwm_7_0,  exp_reg[2]);
        check("reg3", en_reg_pwm_15_8, exp_reg[3]);
        check("reg4", pwm_duty_cycle,  exp_reg[4]);
        check("wr_strobe", wr_strobe, exp_strobe);
        if (wr_strobe === 1'b1) strobes++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n, input int half);
        for (int i = n - 1; i >= 0; i--) begin
            spi.copi = bits[i];
            tick(half);
            spi.sclk = 1'b1;
            tick(half);
            spi.sclk = 1'b0;
        end
    endtask

    // Only the first 16 bits matter; shorter frames, reads and high addresses are dropped
    task automatic end_frame(input logic [31:0] bits, input int n);
        logic [15:0] w;
        commit_t     c;
        spi.ncs = 1'b1;
        if (n >= 16) begin
            w = 16'(bits >> (n - 16));
            if (w[15] && w[14:8] <= 7'h04) begin
                c.at   = cyc + LAT;
                c.addr = w[14:8];
                c.data = w[7:0];
                pend.push_back(c);
                exp_commits++;
            end
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input int half);
        spi.ncs = 1'b0;
        tick(half + 1);
        shift_bits(bits, n, half);
        tick(half);
        end_frame(bits, n);
    endtask

    task automatic summary;
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected finish");
        summary();
        $fatal(1, "timeout");
    end

    logic [15:0] t3[5];
    logic [31:0] bits;
    int          s0, n, half, gap;
    logic [15:0] w;

    initial begin
        t3 = '{16'h80A1, 16'h81B2, 16'h82C3, 16'h83D4, 16'h84E5};
        rst_n    = 1'b0;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        spi.ncs  = 1'b1;

        // 1: reset with random pins
        repeat (5) begin
            spi.sclk = 1'($urandom_range(0, 1));
            spi.copi = 1'($urandom_range(0, 1));
            spi.ncs  = 1'($urandom_range(0, 1));
            tick(1);
        end
        check("rst_reg4", pwm_duty_cycle, 8'h00);
        check("rst_strobe", wr_strobe, 1'b0);
        spi.sclk = 1'b0;
        spi.ncs  = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("idle_reg0", en_reg_out_7_0, 8'h00);
        check("idle_strobes", strobes, 0);

        // 2: single write with latency check
        s0 = strobes;
        send_frame(32'h8455, 16, 5);
        for (int i = 1; i <= LAT; i++) begin
            @(posedge clk);
            #1;
            if (i == LAT - 1) check("lat_before", pwm_duty_cycle, 8'h00);
            if (i == LAT)     check("lat_at", pwm_duty_cycle, 8'h55);
        end
        tick(4);
        check("t2_strobes", strobes - s0, 1);
        check("t2_reg2", en_reg_pwm_7_0, 8'h00);

        // 3: all addresses
        s0 = strobes;
        foreach (t3[i]) begin
            send_frame(32'(t3[i]), 16, 5);
            tick(6);
        end
        tick(6);
        check("t3_reg0", en_reg_out_7_0,  8'hA1);
        check("t3_reg1", en_reg_out_15_8, 8'hB2);
        check("t3_reg2", en_reg_pwm_7_0,  8'hC3);
        check("t3_reg3", en_reg_pwm_15_8, 8'hD4);
        check("t3_reg4", pwm_duty_cycle,  8'hE5);
        check("t3_strobes", strobes - s0, 5);

        // 4: rejected frames
        s0 = strobes;
        send_frame(32'h0477, 16, 5); tick(6);
        send_frame(32'h8533, 16, 5); tick(6);
        send_frame(32'h816, 12, 5);  tick(10);
        check("t4_reg1", en_reg_out_15_8, 8'hB2);
        check("t4_reg4", pwm_duty_cycle,  8'hE5);
        check("t4_strobes", strobes - s0, 0);

        // 5: over-length frame
        s0 = strobes;
        send_frame({12'h000, 16'h82F0, 4'hA}, 20, 5);
        tick(10);
        check("t5_reg2", en_reg_pwm_7_0, 8'hF0);
        check("t5_strobes", strobes - s0, 1);

        // 6a: reset mid-frame, then finish the frame
        s0 = strobes;
        spi.ncs = 1'b0;
        tick(6);
        shift_bits(32'h8399 >> 7, 9, 5);
        tick(2);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(6);
        shift_bits(32'h8399 & 32'h7F, 7, 5);
        tick(5);
        end_frame(32'h8399 & 32'h7F, 7);
        tick(10);
        check("t6_reg2", en_reg_pwm_7_0, 8'h00);
        check("t6_reg3", en_reg_pwm_15_8, 8'h00);
        check("t6_strobes", strobes - s0, 0);

        // 6b: back-to-back with minimum nCS high time
        s0 = strobes;
        send_frame(32'h8011, 16, 5);
        tick(LAT);
        send_frame(32'h8122, 16, 5);
        tick(10);
        check("b2b_reg0", en_reg_out_7_0, 8'h11);
        check("b2b_reg1", en_reg_out_15_8, 8'h22);
        check("b2b_strobes", strobes - s0, 2);

        // Random frames
        for (int k = 0; k < 40; k++) begin
            w[15]   = ($urandom_range(0, 99) < 85);
            w[14:8] = ($urandom_range(0, 3) != 0) ? 7'($urandom_range(0, 4)) : 7'($urandom_range(0, 127));
            w[7:0]  = 8'($urandom);
            n       = ($urandom_range(0, 9) < 7) ? 16 : $urandom_range(8, 22);
            half    = $urandom_range(4, 8);
            gap     = $urandom_range(LAT, 10);
            if (n >= 16) bits = (32'(w) << (n - 16)) | (32'($urandom) & ((32'd1 << (n - 16)) - 32'd1));
            else         bits = 32'(w) >> (16 - n);
            send_frame(bits, n, half);
            if ($urandom_range(0, 3) == 0) begin
                tick(2);
                spi.copi = 1'($urandom_range(0, 1));
                spi.sclk = 1'b1;
                tick(4);
                spi.sclk = 1'b0;
            end
            tick(gap);
        end

        tick(LAT + 6);
        check("drain", pend.size(), 0);
        check("total_strobes", strobes, exp_commits);
        summary();
        $finish;
    end

endmodule
